luna_cpu_ctrl: RTL and testbench

//  Fetch/decode/execute sequencer for the Luna Hack-style CPU. Owns PC, A and D; fetches

---
 rtl/luna_cpu_ctrl_pkg.sv | 61 ++++++
 rtl/luna_cpu_ctrl_if.sv | 34 +++
 rtl/luna_cpu_ctrl_alu.sv | 56 +++++
 rtl/luna_cpu_ctrl.sv | 173 +++++++++++++++++
 tb/tb_luna_cpu_ctrl.sv | 348 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/luna_cpu_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// luna_cpu_ctrl_pkg
//   Shared definitions for the Luna Hack-style CPU controller: sequencer state
//   encoding, instruction field positions, ALU opcodes and the jump condition
//   helper. The instruction field positions assume a 16-bit instruction word.
// ---------------------------------------------------------------------------
package luna_cpu_ctrl_pkg;

  // Sequencer states.
  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_MREAD  = 3'd2,
    ST_EXEC   = 3'd3,
    ST_WB     = 3'd4,
    ST_MWRITE = 3'd5
  } state_e;

  // Instruction field positions.
  localparam int IR_CFLAG    = 15;  // 1 = C-instruction, 0 = A-instruction
  localparam int IR_ABIT     = 12;  // 1 = ALU y operand comes from memory
  localparam int IR_COMP_MSB = 11;
  localparam int IR_COMP_LSB = 6;
  localparam int IR_DEST_MSB = 5;
  localparam int IR_DEST_LSB = 3;
  localparam int IR_JUMP_MSB = 2;
  localparam int IR_JUMP_LSB = 0;

  // Destination field, bit order matches IR[5:3].
  typedef struct packed {
    logic a;
    logic d;
    logic m;
  } dest_t;

  // ALU opcodes (zx nx zy ny f no). x is D, y is A or M.
  localparam logic [5:0] OP_ZERO  = 6'b101010;
  localparam logic [5:0] OP_ONE   = 6'b111111;
  localparam logic [5:0] OP_NEG1  = 6'b111010;
  localparam logic [5:0] OP_X     = 6'b001100;
  localparam logic [5:0] OP_Y     = 6'b110000;
  localparam logic [5:0] OP_NOTX  = 6'b001101;
  localparam logic [5:0] OP_NOTY  = 6'b110001;
  localparam logic [5:0] OP_NEGX  = 6'b001111;
  localparam logic [5:0] OP_NEGY  = 6'b110011;
  localparam logic [5:0] OP_XINC  = 6'b011111;
  localparam logic [5:0] OP_YINC  = 6'b110111;
  localparam logic [5:0] OP_XDEC  = 6'b001110;
  localparam logic [5:0] OP_YDEC  = 6'b110010;
  localparam logic [5:0] OP_ADD   = 6'b000010;
  localparam logic [5:0] OP_XSUBY = 6'b010011;
  localparam logic [5:0] OP_YSUBX = 6'b000111;
  localparam logic [5:0] OP_AND   = 6'b000000;
  localparam logic [5:0] OP_OR    = 6'b010101;

  // Jump decision from the jump field and the result flags.
  function automatic logic jump_taken(input logic [2:0] j, input logic lt, input logic zr);
    return (j[2] & lt) | (j[1] & zr) | (j[0] & ~lt & ~zr);
  endfunction

endpackage

// File: rtl/luna_cpu_ctrl_if.sv
// ---------------------------------------------------------------------------
// luna_cpu_ctrl_if
//   Instruction ROM and data RAM request/acknowledge buses of the controller.
//   Each transfer: req held with address (and we/wdata) stable until the edge
//   where req & ack are both high.
//   master : the controller (drives req/addr/we/wdata, receives ack/data)
//   slave  : the memory side
// ---------------------------------------------------------------------------
interface luna_cpu_ctrl_if #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 15
);
  logic              rom_req;
  logic [ADDR_W-1:0] rom_addr;
  logic              rom_ack;
  logic [WIDTH-1:0]  rom_data;

  logic              ram_req;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [WIDTH-1:0]  ram_wdata;
  logic              ram_ack;
  logic [WIDTH-1:0]  ram_rdata;

  modport master (
    output rom_req, rom_addr, ram_req, ram_we, ram_addr, ram_wdata,
    input  rom_ack, rom_data, ram_ack, ram_rdata
  );

  modport slave (
    input  rom_req, rom_addr, ram_req, ram_we, ram_addr, ram_wdata,
    output rom_ack, rom_data, ram_ack, ram_rdata
  );
endinterface

// File: rtl/luna_cpu_ctrl_alu.sv
// ---------------------------------------------------------------------------
// luna_cpu_ctrl_alu
//   Registered one-cycle Hack ALU. The result of op/x/y is visible on res the
//   cycle after they are presented. Opcodes outside the Hack table yield 0.
//   Ports: clk, rst (async, active-low), op[5:0], x, y, res.
// ---------------------------------------------------------------------------
module luna_cpu_ctrl_alu
  import luna_cpu_ctrl_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       op,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] res
);

  logic [WIDTH-1:0] res_d;

  // NOTE: every combinational output gets a default before the case so no
  // path leaves it unassigned, which would infer a latch.
  always_comb begin
    res_d = '0;
    case (op)
      OP_ZERO:  res_d = '0;
      OP_ONE:   res_d = WIDTH'(1);
      OP_NEG1:  res_d = '1;
      OP_X:     res_d = x;
      OP_Y:     res_d = y;
      OP_NOTX:  res_d = ~x;
      OP_NOTY:  res_d = ~y;
      OP_NEGX:  res_d = -x;
      OP_NEGY:  res_d = -y;
      OP_XINC:  res_d = x + WIDTH'(1);
      OP_YINC:  res_d = y + WIDTH'(1);
      OP_XDEC:  res_d = x - WIDTH'(1);
      OP_YDEC:  res_d = y - WIDTH'(1);
      OP_ADD:   res_d = x + y;
      OP_XSUBY: res_d = x - y;
      OP_YSUBX: res_d = y - x;
      OP_AND:   res_d = x & y;
      OP_OR:    res_d = x | y;
      default:  res_d = '0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) res <= '0;
    else      res <= res_d;
  end

endmodule

// File: rtl/luna_cpu_ctrl.sv
// ---------------------------------------------------------------------------
// luna_cpu_ctrl
//   Fetch/decode/execute sequencer of the Luna Hack-style CPU. Owns PC, A, D,
//   fetches instructions over the ROM bus, reads/writes data RAM over the RAM
//   bus, drives the registered ALU and commits results and jumps.
//   Ports:
//     clk, rst (async, active-low), run (1 = may start the next fetch)
//     bus  : luna_cpu_ctrl_if.master, ROM and RAM handshakes
//     pc_o, a_o, d_o : current PC, A, D (debug)
// ---------------------------------------------------------------------------
module luna_cpu_ctrl
  import luna_cpu_ctrl_pkg::*;
#(
  parameter int                WIDTH    = 16,
  parameter int                ADDR_W   = 15,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  luna_cpu_ctrl_if.master   bus,
  output logic [ADDR_W-1:0] pc_o,
  output logic [WIDTH-1:0]  a_o,
  output logic [WIDTH-1:0]  d_o
);

  state_e state_q, state_d;

  logic [ADDR_W-1:0] pc_q;
  logic [WIDTH-1:0]  a_q, d_q, ir_q, m_q, r_q;
  logic [ADDR_W-1:0] wr_addr_q;    // A captured in WB, used by MWRITE
  logic [ADDR_W-1:0] pc_defer_q;   // PC to commit once MWRITE completes
  logic              fetch_busy_q; // fetch issued and not yet acknowledged

  logic              fetch_req;
  logic              ram_req, ram_we;
  logic [ADDR_W-1:0] ram_addr;

  // Decoded fields.
  dest_t      dest;
  logic [2:0] jump;
  logic [5:0] comp;
  logic       is_c, use_m;
  logic       unused_ir;

  assign is_c      = ir_q[IR_CFLAG];
  assign use_m     = ir_q[IR_ABIT];
  assign comp      = ir_q[IR_COMP_MSB:IR_COMP_LSB];
  assign dest      = ir_q[IR_DEST_MSB:IR_DEST_LSB];
  assign jump      = ir_q[IR_JUMP_MSB:IR_JUMP_LSB];
  assign unused_ir = ^ir_q[14:13];  // C-instruction filler bits carry no meaning

  // ALU: x = D, y = A or M. Its reset is tied inactive; the controller only
  // samples the result in WB, one cycle after EXEC presented the operands.
  logic [WIDTH-1:0] alu_res;

  luna_cpu_ctrl_alu #(.WIDTH(WIDTH)) u_alu (
    .clk (clk),
    .rst (1'b1),
    .op  (comp),
    .x   (d_q),
    .y   (use_m ? m_q : a_q),
    .res (alu_res)
  );

  // Jump resolution. The target is A before any WB write to A.
  logic              res_lt, res_zr, take;
  logic [ADDR_W-1:0] pc_inc, pc_next;

  assign res_lt  = alu_res[WIDTH-1];
  assign res_zr  = (alu_res == '0);
  assign take    = jump_taken(jump, res_lt, res_zr);
  assign pc_inc  = pc_q + ADDR_W'(1);  // wraps at 2^ADDR_W
  assign pc_next = take ? a_q[ADDR_W-1:0] : pc_inc;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_FETCH;
    else      state_q <= state_d;
  end

  // Next state and bus controls.
  always_comb begin
    state_d   = state_q;
    fetch_req = 1'b0;
    ram_req   = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = a_q[ADDR_W-1:0];
    case (state_q)
      ST_FETCH: begin
        // run only matters until a fetch is issued; rst gating keeps the
        // request low during reset even with run held high.
        fetch_req = rst & (run | fetch_busy_q);
        if (fetch_req && bus.rom_ack) state_d = ST_DECODE;
      end
      ST_DECODE: begin
        if (!is_c)      state_d = ST_FETCH;
        else if (use_m) state_d = ST_MREAD;
        else            state_d = ST_EXEC;
      end
      ST_MREAD: begin
        ram_req = 1'b1;
        if (bus.ram_ack) state_d = ST_EXEC;
      end
      ST_EXEC: state_d = ST_WB;
      ST_WB: begin
        state_d = dest.m ? ST_MWRITE : ST_FETCH;
      end
      ST_MWRITE: begin
        ram_req  = 1'b1;
        ram_we   = 1'b1;
        ram_addr = wr_addr_q;
        if (bus.ram_ack) state_d = ST_FETCH;
      end
      default: state_d = ST_FETCH;
    endcase
  end

  // Architectural registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q         <= RESET_PC;
      a_q          <= '0;
      d_q          <= '0;
      ir_q         <= '0;
      m_q          <= '0;
      r_q          <= '0;
      wr_addr_q    <= '0;
      pc_defer_q   <= '0;
      fetch_busy_q <= 1'b0;
    end else begin
      case (state_q)
        ST_FETCH: begin
          fetch_busy_q <= fetch_req & ~bus.rom_ack;
          if (fetch_req && bus.rom_ack) ir_q <= bus.rom_data;
        end
        ST_DECODE: begin
          if (!is_c) begin
            a_q  <= WIDTH'(ir_q[WIDTH-2:0]);
            pc_q <= pc_inc;
          end
        end
        ST_MREAD: begin
          if (bus.ram_ack) m_q <= bus.ram_rdata;
        end
        ST_WB: begin
          r_q       <= alu_res;
          wr_addr_q <= a_q[ADDR_W-1:0];
          if (dest.a) a_q <= alu_res;
          if (dest.d) d_q <= alu_res;
          if (dest.m) pc_defer_q <= pc_next;
          else        pc_q       <= pc_next;
        end
        ST_MWRITE: begin
          if (bus.ram_ack) pc_q <= pc_defer_q;
        end
        default: ;
      endcase
    end
  end

  assign bus.rom_req   = fetch_req;
  assign bus.rom_addr  = pc_q;
  assign bus.ram_req   = ram_req;
  assign bus.ram_we    = ram_we;
  assign bus.ram_addr  = ram_addr;
  assign bus.ram_wdata = r_q;

  assign pc_o = pc_q;
  assign a_o  = a_q;
  assign d_o  = d_q;

endmodule

// File: tb/tb_luna_cpu_ctrl.sv
// ---------------------------------------------------------------------------
// tb_luna_cpu_ctrl
//   Directed bench for luna_cpu_ctrl: small ROM programs with hand-computed
//   expected A/D/PC, RAM traffic and jump targets. A ROM/RAM responder with
//   programmable ack delay models the memories.
// ---------------------------------------------------------------------------
module tb_luna_cpu_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        run = 1'b0;
  logic [14:0] pc_o;
  logic [15:0] a_o, d_o;

  int vectors = 0;
  int fails   = 0;

  luna_cpu_ctrl_if #(.WIDTH(16), .ADDR_W(15)) bus ();

  luna_cpu_ctrl #(.WIDTH(16), .ADDR_W(15), .RESET_PC(15'd0)) dut (
    .clk  (clk),
    .rst  (rst),
    .run  (run),
    .bus  (bus),
    .pc_o (pc_o),
    .a_o  (a_o),
    .d_o  (d_o)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Memory models and responder state.
  logic [15:0] rom [64];
  logic [15:0] ram [64];
  int          rom_delay = 0;
  int          ram_delay = 0;
  bit          stray_ack = 1'b0;
  int          unstable  = 0;
  int          wr_cnt    = 0;
  int          rd_cnt    = 0;
  logic [14:0] wr_addr_log, rd_addr_log;
  logic [15:0] wr_data_log;

  initial begin
    int          rom_wait = 0;
    int          ram_wait = 0;
    logic [14:0] rom_addr_hold = '0;
    logic [14:0] ram_addr_hold = '0;
    logic        ram_we_hold   = 1'b0;
    logic [15:0] ram_wdata_hold = '0;
    bus.rom_ack   = 1'b0;
    bus.rom_data  = '0;
    bus.ram_ack   = 1'b0;
    bus.ram_rdata = '0;
    forever begin
      @(negedge clk);
      if (stray_ack) begin
        bus.rom_ack = 1'b1;
        bus.ram_ack = 1'b1;
        rom_wait    = 0;
        ram_wait    = 0;
      end else begin
        if (bus.rom_req) begin
          if (rom_wait == 0) rom_addr_hold = bus.rom_addr;
          else if (bus.rom_addr !== rom_addr_hold) unstable++;
          if (rom_wait >= rom_delay) begin
            bus.rom_ack  = 1'b1;
            bus.rom_data = rom[bus.rom_addr[5:0]];
            rom_wait     = 0;
          end else begin
            bus.rom_ack = 1'b0;
            rom_wait++;
          end
        end else begin
          bus.rom_ack = 1'b0;
          rom_wait    = 0;
        end
        if (bus.ram_req) begin
          if (ram_wait == 0) begin
            ram_addr_hold  = bus.ram_addr;
            ram_we_hold    = bus.ram_we;
            ram_wdata_hold = bus.ram_wdata;
          end else if (bus.ram_addr !== ram_addr_hold || bus.ram_we !== ram_we_hold ||
                       (bus.ram_we && bus.ram_wdata !== ram_wdata_hold)) begin
            unstable++;
          end
          if (ram_wait >= ram_delay) begin
            bus.ram_ack = 1'b1;
            if (bus.ram_we) begin
              ram[bus.ram_addr[5:0]] = bus.ram_wdata;
              wr_addr_log = bus.ram_addr;
              wr_data_log = bus.ram_wdata;
              wr_cnt++;
            end else begin
              bus.ram_rdata = ram[bus.ram_addr[5:0]];
              rd_addr_log   = bus.ram_addr;
              rd_cnt++;
            end
            ram_wait = 0;
          end else begin
            bus.ram_ack = 1'b0;
            ram_wait++;
          end
        end else begin
          bus.ram_ack = 1'b0;
          ram_wait    = 0;
        end
      end
    end
  end

  // ---------------- helpers (stimulus / bounded waits) ----------------
  task automatic clear_mem();
    for (int i = 0; i < 64; i++) begin
      rom[i] = 16'h0000;
      ram[i] = 16'h0000;
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    run = 1'b0;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1;
    rst       = 1'b1;
    wr_cnt    = 0;
    rd_cnt    = 0;
    unstable  = 0;
  endtask

  task automatic start_run();
    @(posedge clk);
    #1 run = 1'b1;
  endtask

  task automatic wait_fetch(input logic [14:0] addr, output int cycles);
    bit hit = 1'b0;
    cycles = 0;
    while (!hit && cycles < 200) begin
      @(negedge clk);
      cycles++;
      if (bus.rom_req && bus.rom_addr == addr) hit = 1'b1;
    end
    if (!hit) begin
      vectors++;
      fails++;
      $display("FAIL fetch_timeout: no fetch of address %0d after %0d cycles", addr, cycles);
    end
  endtask

  task automatic next_fetch(output logic [14:0] addr);
    int n = 0;
    while (bus.rom_req && n < 200) begin @(negedge clk); n++; end
    while (!bus.rom_req && n < 200) begin @(negedge clk); n++; end
    addr = bus.rom_addr;
    if (n >= 200) begin
      vectors++;
      fails++;
      $display("FAIL next_fetch_timeout: no new fetch within %0d cycles", n);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b0;
    run = 1'b1;  // reset must dominate run
    repeat (2) @(negedge clk);
    vectors++; if (bus.rom_req !== 1'b0) begin fails++; $display("FAIL reset_rom_req: got %b want 0", bus.rom_req); end
    vectors++; if (bus.ram_req !== 1'b0) begin fails++; $display("FAIL reset_ram_req: got %b want 0", bus.ram_req); end
    vectors++; if (bus.ram_we !== 1'b0) begin fails++; $display("FAIL reset_ram_we: got %b want 0", bus.ram_we); end
    vectors++; if (bus.ram_wdata !== 16'h0000) begin fails++; $display("FAIL reset_ram_wdata: got %h want 0000", bus.ram_wdata); end
    vectors++; if (pc_o !== 15'd0) begin fails++; $display("FAIL reset_pc: got %0d want 0", pc_o); end
    vectors++; if (a_o !== 16'h0000 || d_o !== 16'h0000) begin fails++; $display("FAIL reset_ad: got A=%h D=%h want 0000 0000", a_o, d_o); end
    run = 1'b0;
  endtask

  task automatic test_a_then_c();
    int c;
    clear_mem();
    rom[0] = 16'h0005;  // @5
    rom[1] = 16'hEC10;  // D=A
    do_reset();
    start_run();
    wait_fetch(15'd0, c);
    wait_fetch(15'd1, c);
    vectors++; if (c != 2) begin fails++; $display("FAIL ainstr_latency: got %0d cycles want 2", c); end
    vectors++; if (a_o !== 16'h0005 || d_o !== 16'h0000) begin fails++; $display("FAIL ainstr_commit: got A=%h D=%h want 0005 0000", a_o, d_o); end
    wait_fetch(15'd2, c);
    vectors++; if (a_o !== 16'h0005 || d_o !== 16'h0005 || pc_o !== 15'd2) begin
      fails++; $display("FAIL d_eq_a: got A=%h D=%h PC=%0d want 0005 0005 2", a_o, d_o, pc_o);
    end
  endtask

  task automatic test_mem_rmw();
    int c;
    clear_mem();
    rom[0]  = 16'h0010;  // @16
    rom[1]  = 16'hFDC8;  // M=M+1
    ram[16] = 16'h0007;
    do_reset();
    start_run();
    wait_fetch(15'd2, c);
    vectors++; if (rd_cnt != 1 || rd_addr_log !== 15'd16) begin fails++; $display("FAIL rmw_read: got %0d reads addr %0d want 1 addr 16", rd_cnt, rd_addr_log); end
    vectors++; if (wr_cnt != 1 || wr_addr_log !== 15'd16 || wr_data_log !== 16'h0008) begin
      fails++; $display("FAIL rmw_write: got %0d writes addr %0d data %h want 1 addr 16 data 0008", wr_cnt, wr_addr_log, wr_data_log);
    end
    vectors++; if (pc_o !== 15'd2 || a_o !== 16'h0010) begin fails++; $display("FAIL rmw_regs: got PC=%0d A=%h want 2 0010", pc_o, a_o); end
  endtask

  task automatic test_jumps();
    // {D-setting instr, jump instr, expected next fetch}; A=3, jump sits at 3
    logic [15:0] d_ins [5] = '{16'hEE90, 16'hEA90, 16'hEA90, 16'hEA90, 16'hEE90};
    logic [15:0] j_ins [5] = '{16'hE304, 16'hE304, 16'hEA87, 16'hE302, 16'hE301};
    logic [14:0] exp_pc [5] = '{15'd3, 15'd4, 15'd3, 15'd3, 15'd4};
    for (int i = 0; i < 5; i++) begin
      int c;
      logic [14:0] got;
      clear_mem();
      rom[0] = d_ins[i];
      rom[1] = 16'h0003;
      rom[2] = 16'h0003;
      rom[3] = j_ins[i];
      do_reset();
      start_run();
      wait_fetch(15'd3, c);
      next_fetch(got);
      vectors++; if (got !== exp_pc[i] || pc_o !== exp_pc[i]) begin
        fails++; $display("FAIL jump_%0d: got fetch %0d PC=%0d want %0d", i, got, pc_o, exp_pc[i]);
      end
      if (i == 0) begin
        vectors++; if (d_o !== 16'hFFFF) begin fails++; $display("FAIL jump_d_kept: got D=%h want FFFF", d_o); end
      end
    end
  endtask

  task automatic test_dest_and_jump();
    int c;
    logic [14:0] got;
    clear_mem();
    rom[0] = 16'h0005;  // @5
    rom[1] = 16'hEC10;  // D=A
    rom[2] = 16'h0014;  // @20
    rom[3] = 16'hE327;  // A=D;JMP
    do_reset();
    start_run();
    wait_fetch(15'd3, c);
    next_fetch(got);
    vectors++; if (got !== 15'd20 || a_o !== 16'h0005 || d_o !== 16'h0005) begin
      fails++; $display("FAIL a_eq_d_jmp: got fetch %0d A=%h D=%h want 20 0005 0005", got, a_o, d_o);
    end
    rom[3] = 16'hE33F;  // AMD=D;JMP
    do_reset();
    start_run();
    wait_fetch(15'd3, c);
    next_fetch(got);
    vectors++; if (got !== 15'd20 || pc_o !== 15'd20 || a_o !== 16'h0005) begin
      fails++; $display("FAIL amd_jmp_regs: got fetch %0d PC=%0d A=%h want 20 20 0005", got, pc_o, a_o);
    end
    vectors++; if (wr_cnt != 1 || wr_addr_log !== 15'd20 || wr_data_log !== 16'h0005 || ram[20] !== 16'h0005) begin
      fails++; $display("FAIL amd_jmp_mem: got %0d writes addr %0d data %h want 1 addr 20 data 0005", wr_cnt, wr_addr_log, wr_data_log);
    end
  endtask

  task automatic test_handshake_delay();
    int c;
    rom_delay = 3;
    ram_delay = 2;
    clear_mem();
    rom[0] = 16'h0005;
    rom[1] = 16'hEC10;
    do_reset();
    start_run();
    wait_fetch(15'd0, c);
    wait_fetch(15'd1, c);
    vectors++; if (c != 5) begin fails++; $display("FAIL delayed_fetch_latency: got %0d cycles want 5", c); end
    wait_fetch(15'd2, c);
    vectors++; if (a_o !== 16'h0005 || d_o !== 16'h0005) begin fails++; $display("FAIL delayed_d_eq_a: got A=%h D=%h want 0005 0005", a_o, d_o); end
    clear_mem();
    rom[0]  = 16'h0010;
    rom[1]  = 16'hFDC8;
    ram[16] = 16'h0007;
    do_reset();
    start_run();
    wait_fetch(15'd2, c);
    vectors++; if (ram[16] !== 16'h0008 || pc_o !== 15'd2) begin fails++; $display("FAIL delayed_rmw: got M[16]=%h PC=%0d want 0008 2", ram[16], pc_o); end
    vectors++; if (unstable != 0) begin fails++; $display("FAIL bus_stability: got %0d unstable samples want 0", unstable); end
    rom_delay = 0;
    ram_delay = 0;
  endtask

  task automatic test_reset_mid_write();
    int c;
    int n = 0;
    int req_seen = 0;
    clear_mem();
    rom[0]  = 16'h0010;
    rom[1]  = 16'hFDC8;
    ram[16] = 16'h0007;
    ram_delay = 5;
    do_reset();
    start_run();
    while (!(bus.ram_req && bus.ram_we) && n < 200) begin @(negedge clk); n++; end
    vectors++; if (n >= 200) begin fails++; $display("FAIL mwrite_timeout: no write request after %0d cycles", n); end
    rst = 1'b0;
    #1;
    vectors++; if (bus.ram_req !== 1'b0 || bus.ram_we !== 1'b0 || bus.ram_wdata !== 16'h0000 || bus.rom_req !== 1'b0) begin
      fails++; $display("FAIL midreset_bus: got ram_req=%b we=%b wdata=%h rom_req=%b want 0 0 0000 0", bus.ram_req, bus.ram_we, bus.ram_wdata, bus.rom_req);
    end
    vectors++; if (pc_o !== 15'd0 || a_o !== 16'h0000) begin fails++; $display("FAIL midreset_regs: got PC=%0d A=%h want 0 0000", pc_o, a_o); end
    stray_ack = 1'b1;
    run = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (bus.rom_req || bus.ram_req) req_seen++;
    end
    vectors++; if (req_seen != 0) begin fails++; $display("FAIL no_req_when_parked: got %0d request cycles want 0", req_seen); end
    vectors++; if (pc_o !== 15'd0 || wr_cnt != 0 || ram[16] !== 16'h0007) begin
      fails++; $display("FAIL stray_ack_ignored: got PC=%0d writes=%0d M[16]=%h want 0 0 0007", pc_o, wr_cnt, ram[16]);
    end
    stray_ack = 1'b0;
    ram_delay = 0;
    start_run();
    wait_fetch(15'd1, c);
    vectors++; if (a_o !== 16'h0010) begin fails++; $display("FAIL restart_after_reset: got A=%h want 0010", a_o); end
  endtask

  initial begin
    test_reset();
    test_a_then_c();
    test_mem_rmw();
    test_jumps();
    test_dest_and_jump();
    test_handshake_delay();
    test_reset_mid_write();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
